// File: rtl/calc2_resp_reorder_if.sv
// Handshake bundle for one calc2_resp_reorder instance: the request issue
// channel, the out-of-order response port coming back from calc2_top, the
// ordered valid/ready release stream and the status outputs.
interface calc2_resp_reorder_if #(
   parameter int DATA_W = 32,
   parameter int TAG_W  = 2
);
   // request issue channel
   logic              issue_valid;
   logic [TAG_W-1:0]  issue_tag;
   logic              issue_ready;

   // response port from calc2_top (out_respN/out_dataN/out_tagN)
   logic [1:0]        in_resp;
   logic [DATA_W-1:0] in_data;
   logic [TAG_W-1:0]  in_tag;

   // ordered release stream
   logic              o_valid;
   logic              o_ready;
   logic [1:0]        o_resp;
   logic [DATA_W-1:0] o_data;
   logic [TAG_W-1:0]  o_tag;

   // status
   logic [TAG_W:0]    outstanding;
   logic              err_unexpected;

   // Environment side: issues requests, replays calc2_top responses, consumes the stream.
   modport master (
      output issue_valid, issue_tag,
      input  issue_ready,
      output in_resp, in_data, in_tag,
      input  o_valid,
      output o_ready,
      input  o_resp, o_data, o_tag, outstanding, err_unexpected
   );

   // Reorder block side.
   modport slave (
      input  issue_valid, issue_tag,
      output issue_ready,
      input  in_resp, in_data, in_tag,
      output o_valid,
      input  o_ready,
      output o_resp, o_data, o_tag, outstanding, err_unexpected
   );
endinterface

// File: rtl/calc2_resp_reorder.sv
// Per-port response collector for one calc2_top output port.
// Records the order in which tags are issued, parks responses that come back
// early, and releases them in issue order through a single output register.
// A head tag that waits TIMEOUT cycles is released as a timeout response so
// the stream can never stall forever.
module calc2_resp_reorder #(
   parameter int DATA_W  = 32,
   parameter int TAG_W   = 2,
   parameter int TIMEOUT = 64
) (
   input  logic                 c_clk,
   input  logic                 reset,
   calc2_resp_reorder_if.slave  bus
);

   localparam int SLOTS = 2 ** TAG_W;
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] TMO_MAX  = CNT_W'(TIMEOUT);
   localparam logic [TAG_W:0]   OCC_FULL = (TAG_W + 1)'(SLOTS);

   localparam logic [1:0] RESP_NONE = 2'b00;
   localparam logic [1:0] RESP_TMO  = 2'b11;

   typedef logic [TAG_W-1:0] tag_t;

   // Single output register; one struct so it loads and resets as a unit.
   typedef struct packed {
      logic              valid;
      logic [1:0]        resp;
      logic [DATA_W-1:0] data;
      tag_t              tag;
   } out_reg_t;

   // ---------------------------------------------------------------------
   // Storage (payload only; validity lives in the control registers)
   // ---------------------------------------------------------------------
   tag_t              fifo_mem  [SLOTS];
   logic [1:0]        slot_resp [SLOTS];
   logic [DATA_W-1:0] slot_data [SLOTS];

   // ---------------------------------------------------------------------
   // Control state
   // ---------------------------------------------------------------------
   tag_t              rd_ptr_q,     rd_ptr_d;
   tag_t              wr_ptr_q,     wr_ptr_d;
   logic [TAG_W:0]    count_q,      count_d;
   logic [SLOTS-1:0]  pending_q,    pending_d;
   logic [SLOTS-1:0]  slot_valid_q, slot_valid_d;
   logic [CNT_W-1:0]  tmo_cnt_q,    tmo_cnt_d;
   out_reg_t          out_q,        out_d;
   logic              err_q,        err_d;

   // ---------------------------------------------------------------------
   // Decode of the current cycle's events
   // ---------------------------------------------------------------------
   logic fifo_empty;
   logic fifo_full;
   tag_t head_tag;
   logic head_ready;
   logic rel_allowed;
   logic tmo_due;
   logic pop_ok;
   logic pop_tmo;
   logic pop;
   logic issue_ready;
   logic push;
   logic resp_seen;
   logic capture;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == OCC_FULL);
   assign head_tag   = fifo_mem[rd_ptr_q];
   assign head_ready = slot_valid_q[head_tag];

   // The output register can take a new response when it is empty or being drained.
   assign rel_allowed = !fifo_empty && (!out_q.valid || bus.o_ready);

   // The count is about to reach TIMEOUT this cycle (or already sits there while stalled).
   assign tmo_due = !fifo_empty && !head_ready && (tmo_cnt_q >= TMO_LAST);

   assign pop_ok  = rel_allowed && head_ready;
   assign pop_tmo = rel_allowed && tmo_due;
   assign pop     = pop_ok || pop_tmo;

   // Issue acceptance looks only at registered state; a same-cycle pop frees nothing.
   assign issue_ready = !fifo_full && !pending_q[bus.issue_tag];
   assign push        = bus.issue_valid && issue_ready;

   // A response is kept only for a pending tag with an empty slot; a response for the
   // head that collides with its own timeout release loses and is flagged.
   assign resp_seen = (bus.in_resp != RESP_NONE);
   assign capture   = resp_seen
                      && pending_q[bus.in_tag]
                      && !slot_valid_q[bus.in_tag]
                      && !(pop_tmo && (bus.in_tag == head_tag));

   // Next-state logic for pointers, occupancy, per-tag bits, timeout and output register.
   always_comb begin
      // NOTE: every variable gets its default first so no path leaves one unassigned (no latches).
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      count_d      = count_q;
      pending_d    = pending_q;
      slot_valid_d = slot_valid_q;
      tmo_cnt_d    = tmo_cnt_q;
      out_d        = out_q;
      err_d        = resp_seen && !capture;

      if (push) begin
         wr_ptr_d                 = wr_ptr_q + tag_t'(1);
         pending_d[bus.issue_tag] = 1'b1;
      end

      if (capture) begin
         slot_valid_d[bus.in_tag] = 1'b1;
      end

      // Pop last: the head tag can never be the pushed tag (it is pending), and it can
      // only match a captured tag in the timeout-collision case, which capture excludes.
      if (pop) begin
         rd_ptr_d               = rd_ptr_q + tag_t'(1);
         pending_d[head_tag]    = 1'b0;
         slot_valid_d[head_tag] = 1'b0;
      end

      unique case ({push, pop})
         2'b10:   count_d = count_q + (TAG_W + 1)'(1);
         2'b01:   count_d = count_q - (TAG_W + 1)'(1);
         default: count_d = count_q;
      endcase

      // Time the head's wait; saturate at TIMEOUT while the output is stalled.
      if (pop) begin
         tmo_cnt_d = '0;
      end else if (!fifo_empty && !head_ready && (tmo_cnt_q != TMO_MAX)) begin
         tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
      end

      if (pop) begin
         out_d.valid = 1'b1;
         out_d.resp  = pop_ok ? slot_resp[head_tag] : RESP_TMO;
         out_d.data  = pop_ok ? slot_data[head_tag] : '0;
         out_d.tag   = head_tag;
      end else if (bus.o_ready) begin
         out_d.valid = 1'b0;
      end
   end

   // Control registers: asynchronous reset discards every parked response.
   always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
         pending_q    <= '0;
         slot_valid_q <= '0;
         tmo_cnt_q    <= '0;
         out_q        <= '0;
         err_q        <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
         pending_q    <= pending_d;
         slot_valid_q <= slot_valid_d;
         tmo_cnt_q    <= tmo_cnt_d;
         out_q        <= out_d;
         err_q        <= err_d;
      end
   end

   // Payload storage writes: issued tags into the order FIFO, responses into their slots.
   // NOTE: storage arrays have no reset; count/pending/slot_valid gate every read of them.
   always_ff @(posedge c_clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= bus.issue_tag;
      end
      if (capture) begin
         slot_resp[bus.in_tag] <= bus.in_resp;
         slot_data[bus.in_tag] <= bus.in_data;
      end
   end

   assign bus.issue_ready    = issue_ready;
   assign bus.o_valid        = out_q.valid;
   assign bus.o_resp         = out_q.resp;
   assign bus.o_data         = out_q.data;
   assign bus.o_tag          = out_q.tag;
   assign bus.outstanding    = count_q;
   assign bus.err_unexpected = err_q;

endmodule

// File: tb/tb_calc2_resp_reorder.sv
// Directed bench for calc2_resp_reorder: a vector table covers in-order,
// reordered, back-pressured and illegal traffic cycle by cycle; hand-written
// sequences cover error/timeout release, the timeout/response collision and
// reset in the middle of traffic.
module tb_calc2_resp_reorder;

   localparam int DATA_W  = 32;
   localparam int TAG_W   = 2;
   localparam int TIMEOUT = 16;

   // One cycle of stimulus plus the outputs expected before that cycle's edge.
   typedef struct packed {
      logic        iv;
      logic [1:0]  itag;
      logic [1:0]  rsp;
      logic [31:0] dat;
      logic [1:0]  rtag;
      logic        ordy;
      logic        e_ir;
      logic        e_ov;
      logic [1:0]  e_resp;
      logic [31:0] e_data;
      logic [1:0]  e_tag;
      logic [2:0]  e_out;
      logic        e_err;
   } vec_t;

   logic  c_clk = 1'b0;
   logic  reset = 1'b0;
   int    n_checks = 0;
   int    n_errors = 0;
   vec_t  vecs[$];
   string names[$];

   calc2_resp_reorder_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

   calc2_resp_reorder #(
      .DATA_W  (DATA_W),
      .TAG_W   (TAG_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .c_clk (c_clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 c_clk = ~c_clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic iv, input logic [1:0] itag, input logic [1:0] rsp,
                        input logic [31:0] dat, input logic [1:0] rtag, input logic ordy);
      bus.issue_valid = iv;
      bus.issue_tag   = itag;
      bus.in_resp     = rsp;
      bus.in_data     = dat;
      bus.in_tag      = rtag;
      bus.o_ready     = ordy;
   endtask

   task automatic check_out(input string name, input logic ov, input logic [1:0] resp,
                            input logic [31:0] data, input logic [1:0] tag,
                            input logic [2:0] out, input logic err);
      check({name, " o_valid"}, bus.o_valid, ov);
      check({name, " outstanding"}, bus.outstanding, out);
      check({name, " err_unexpected"}, bus.err_unexpected, err);
      if (ov) begin
         check({name, " o_resp"}, bus.o_resp, resp);
         check({name, " o_data"}, bus.o_data, data);
         check({name, " o_tag"}, bus.o_tag, tag);
      end
   endtask

   task automatic add(input string name,
                      input logic iv, input logic [1:0] itag,
                      input logic [1:0] rsp, input logic [31:0] dat, input logic [1:0] rtag,
                      input logic ordy, input logic e_ir, input logic e_ov,
                      input logic [1:0] e_resp, input logic [31:0] e_data, input logic [1:0] e_tag,
                      input logic [2:0] e_out, input logic e_err);
      vec_t v;
      v.iv = iv;      v.itag = itag;     v.rsp = rsp;       v.dat = dat;
      v.rtag = rtag;  v.ordy = ordy;     v.e_ir = e_ir;     v.e_ov = e_ov;
      v.e_resp = e_resp; v.e_data = e_data; v.e_tag = e_tag;
      v.e_out = e_out;   v.e_err = e_err;
      vecs.push_back(v);
      names.push_back(name);
   endtask

   task automatic apply_vec(input vec_t v, input string name);
      @(negedge c_clk);
      drive(v.iv, v.itag, v.rsp, v.dat, v.rtag, v.ordy);
      #1;
      check({name, " issue_ready"}, bus.issue_ready, v.e_ir);
      check_out(name, v.e_ov, v.e_resp, v.e_data, v.e_tag, v.e_out, v.e_err);
   endtask

   // Watchdog: the bench must never hang.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int wait_n;

      //            name    iv it  rsp  data      rt ordy ir ov resp  data      tg out err
      // in-order
      add("IO0",   1, 0, 2'b00, 32'h0,   0, 1,   1, 0, 2'b00, 32'h0,   0, 0, 0);
      add("IO1",   1, 1, 2'b00, 32'h0,   0, 1,   1, 0, 2'b00, 32'h0,   0, 1, 0);
      add("IO2",   0, 3, 2'b01, 32'h159, 0, 1,   1, 0, 2'b00, 32'h0,   0, 2, 0);
      add("IO3",   0, 3, 2'b01, 32'h146, 1, 1,   1, 0, 2'b00, 32'h0,   0, 2, 0);
      add("IO4",   0, 3, 2'b00, 32'h0,   0, 1,   1, 1, 2'b01, 32'h159, 0, 1, 0);
      add("IO5",   0, 3, 2'b00, 32'h0,   0, 1,   1, 1, 2'b01, 32'h146, 1, 0, 0);
      add("IO6",   0, 3, 2'b00, 32'h0,   0, 1,   1, 0, 2'b00, 32'h0,   0, 0, 0);
      // reorder: responses 3,1,0,2, released 0,1,2,3; full blocks issue
      add("RO0",   1, 0, 2'b00, 32'h0,   0, 1,   1, 0, 2'b00, 32'h0,   0, 0, 0);
      add("RO1",   1, 1, 2'b00, 32'h0,   0, 1,   1, 0, 2'b00, 32'h0,   0, 1, 0);
      add("RO2",   1, 2, 2'b00, 32'h0,   0, 1,   1, 0, 2'b00, 32'h0,   0, 2, 0);
      add("RO3",   1, 3, 2'b00, 32'h0,   0, 1,   1, 0, 2'b00, 32'h0,   0, 3, 0);
      add("RO4",   1, 0, 2'b01, 32'h33,  3, 1,   0, 0, 2'b00, 32'h0,   0, 4, 0);
      add("RO5",   0, 0, 2'b01, 32'h31,  1, 1,   0, 0, 2'b00, 32'h0,   0, 4, 0);
      add("RO6",   0, 0, 2'b01, 32'h30,  0, 1,   0, 0, 2'b00, 32'h0,   0, 4, 0);
      add("RO7",   0, 0, 2'b01, 32'h32,  2, 1,   0, 0, 2'b00, 32'h0,   0, 4, 0);
      add("RO8",   0, 0, 2'b00, 32'h0,   0, 1,   1, 1, 2'b01, 32'h30,  0, 3, 0);
      add("RO9",   0, 0, 2'b00, 32'h0,   0, 1,   1, 1, 2'b01, 32'h31,  1, 2, 0);
      add("RO10",  0, 0, 2'b00, 32'h0,   0, 1,   1, 1, 2'b01, 32'h32,  2, 1, 0);
      add("RO11",  0, 0, 2'b00, 32'h0,   0, 1,   1, 1, 2'b01, 32'h33,  3, 0, 0);
      add("RO12",  0, 0, 2'b00, 32'h0,   0, 1,   1, 0, 2'b00, 32'h0,   0, 0, 0);
      // backpressure: output held, then two back-to-back releases
      add("BP0",   1, 0, 2'b00, 32'h0,   0, 0,   1, 0, 2'b00, 32'h0,   0, 0, 0);
      add("BP1",   1, 1, 2'b01, 32'h40,  0, 0,   1, 0, 2'b00, 32'h0,   0, 1, 0);
      add("BP2",   0, 3, 2'b01, 32'h41,  1, 0,   1, 0, 2'b00, 32'h0,   0, 2, 0);
      add("BP3",   0, 3, 2'b00, 32'h0,   0, 0,   1, 1, 2'b01, 32'h40,  0, 1, 0);
      add("BP4",   0, 3, 2'b00, 32'h0,   0, 0,   1, 1, 2'b01, 32'h40,  0, 1, 0);
      add("BP5",   0, 3, 2'b00, 32'h0,   0, 0,   1, 1, 2'b01, 32'h40,  0, 1, 0);
      add("BP6",   0, 3, 2'b00, 32'h0,   0, 1,   1, 1, 2'b01, 32'h40,  0, 1, 0);
      add("BP7",   0, 3, 2'b00, 32'h0,   0, 1,   1, 1, 2'b01, 32'h41,  1, 0, 0);
      add("BP8",   0, 3, 2'b00, 32'h0,   0, 1,   1, 0, 2'b00, 32'h0,   0, 0, 0);
      // illegal: duplicate issue blocked, never-issued and duplicate responses flagged
      add("IL0",   1, 0, 2'b00, 32'h0,   0, 1,   1, 0, 2'b00, 32'h0,   0, 0, 0);
      add("IL1",   1, 0, 2'b00, 32'h0,   0, 1,   0, 0, 2'b00, 32'h0,   0, 1, 0);
      add("IL2",   1, 0, 2'b01, 32'h55,  0, 1,   0, 0, 2'b00, 32'h0,   0, 1, 0);
      add("IL3",   1, 0, 2'b00, 32'h0,   0, 1,   0, 0, 2'b00, 32'h0,   0, 1, 0);
      add("IL4",   1, 0, 2'b00, 32'h0,   0, 1,   1, 1, 2'b01, 32'h55,  0, 0, 0);
      add("IL5",   0, 0, 2'b00, 32'h0,   0, 1,   0, 0, 2'b00, 32'h0,   0, 1, 0);
      add("IL6",   0, 3, 2'b01, 32'h77,  2, 1,   1, 0, 2'b00, 32'h0,   0, 1, 0);
      add("IL7",   0, 3, 2'b00, 32'h0,   0, 1,   1, 0, 2'b00, 32'h0,   0, 1, 1);
      add("IL8",   0, 3, 2'b01, 32'h66,  0, 1,   1, 0, 2'b00, 32'h0,   0, 1, 0);
      add("IL9",   0, 3, 2'b01, 32'h99,  0, 1,   1, 0, 2'b00, 32'h0,   0, 1, 0);
      add("IL10",  0, 3, 2'b00, 32'h0,   0, 1,   1, 1, 2'b01, 32'h66,  0, 0, 1);
      add("IL11",  0, 3, 2'b00, 32'h0,   0, 1,   1, 0, 2'b00, 32'h0,   0, 0, 0);

      // ---------------- reset state ----------------
      drive(0, 0, 2'b00, 32'h0, 0, 1);
      repeat (2) @(negedge c_clk);
      #1;
      check("reset issue_ready", bus.issue_ready, 1'b1);
      check("reset o_valid", bus.o_valid, 1'b0);
      check("reset o_resp", bus.o_resp, 2'b00);
      check("reset o_data", bus.o_data, 32'h0);
      check("reset o_tag", bus.o_tag, 2'd0);
      check("reset outstanding", bus.outstanding, 3'd0);
      check("reset err_unexpected", bus.err_unexpected, 1'b0);
      reset = 1'b1;

      // ---------------- vector table ----------------
      for (int i = 0; i < vecs.size(); i++) begin
         apply_vec(vecs[i], names[i]);
      end

      // ---------------- error response, then timeout of an unanswered tag ----------------
      @(negedge c_clk); drive(1, 2, 2'b00, 32'h0, 0, 1);
      @(negedge c_clk); drive(1, 1, 2'b00, 32'h0, 0, 1);
      @(negedge c_clk); drive(0, 3, 2'b10, 32'h0, 2, 1);
      @(negedge c_clk); drive(0, 3, 2'b00, 32'h0, 0, 1);
      @(negedge c_clk); #1;
      check_out("ERR tag2", 1'b1, 2'b10, 32'h0, 2'd2, 3'd1, 1'b0);

      wait_n = TIMEOUT + 5;
      for (int i = 1; i <= TIMEOUT + 4; i++) begin
         @(negedge c_clk);
         if (bus.o_valid) begin
            wait_n = i;
            break;
         end
      end
      #1;
      check("TMO cycles from head", wait_n, TIMEOUT);
      check_out("TMO tag1", 1'b1, 2'b11, 32'h0, 2'd1, 3'd0, 1'b0);

      // late response for the timed-out tag
      drive(0, 3, 2'b01, 32'h12, 1, 1);
      @(negedge c_clk); #1;
      drive(0, 3, 2'b00, 32'h0, 0, 1);
      check_out("LATE tag1", 1'b0, 2'b00, 32'h0, 2'd0, 3'd0, 1'b1);
      @(negedge c_clk); #1;
      check_out("LATE after", 1'b0, 2'b00, 32'h0, 2'd0, 3'd0, 1'b0);

      // ---------------- head response colliding with its timeout release ----------------
      drive(1, 3, 2'b00, 32'h0, 0, 1);
      @(negedge c_clk);
      drive(0, 0, 2'b00, 32'h0, 0, 1);
      repeat (TIMEOUT - 1) @(negedge c_clk);
      #1;
      check_out("RACE before", 1'b0, 2'b00, 32'h0, 2'd0, 3'd1, 1'b0);
      drive(0, 0, 2'b01, 32'hAB, 3, 1);
      @(negedge c_clk); #1;
      drive(0, 0, 2'b00, 32'h0, 0, 1);
      check_out("RACE release", 1'b1, 2'b11, 32'h0, 2'd3, 3'd0, 1'b1);
      @(negedge c_clk); #1;
      check_out("RACE after", 1'b0, 2'b00, 32'h0, 2'd0, 3'd0, 1'b0);

      // ---------------- reset in the middle of traffic ----------------
      for (int t = 0; t < 4; t++) begin
         drive(1, 2'(t), 2'b00, 32'h0, 0, 0);
         @(negedge c_clk);
      end
      drive(0, 0, 2'b01, 32'hC0, 0, 0);
      @(negedge c_clk);
      drive(0, 0, 2'b01, 32'hC1, 1, 0);
      @(negedge c_clk);
      drive(0, 0, 2'b00, 32'h0, 0, 0);
      #1;
      check_out("RST before", 1'b1, 2'b01, 32'hC0, 2'd0, 3'd3, 1'b0);
      reset = 1'b0;
      #1;
      check("RST issue_ready", bus.issue_ready, 1'b1);
      check("RST o_valid", bus.o_valid, 1'b0);
      check("RST o_resp", bus.o_resp, 2'b00);
      check("RST o_data", bus.o_data, 32'h0);
      check("RST o_tag", bus.o_tag, 2'd0);
      check("RST outstanding", bus.outstanding, 3'd0);
      check("RST err_unexpected", bus.err_unexpected, 1'b0);
      @(negedge c_clk);
      reset = 1'b1;
      drive(1, 0, 2'b00, 32'h0, 0, 1);
      #1;
      check("FRESH issue_ready tag0", bus.issue_ready, 1'b1);
      @(negedge c_clk);
      drive(0, 0, 2'b01, 32'hC1, 1, 1);
      #1;
      check_out("FRESH issued", 1'b0, 2'b00, 32'h0, 2'd0, 3'd1, 1'b0);
      @(negedge c_clk);
      drive(0, 0, 2'b00, 32'h0, 0, 1);
      #1;
      check_out("STALE tag1", 1'b0, 2'b00, 32'h0, 2'd0, 3'd1, 1'b1);
      @(negedge c_clk); #1;
      check_out("STALE after", 1'b0, 2'b00, 32'h0, 2'd0, 3'd1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
